tmr_intc: RTL and testbench

Interrupt controller that receives the compare-match A/B and overflow interrupt lines of the four 8-bit timer channels (two units) and presents them to the CPU one at a time. Rising edges on the source lines latch pending flags. Unmasked pending flags are arbitrated by fixed priority, and the winning vector is held through a request/acknowledge handshake. The block sits between the timer units and the CPU interrupt input.

---
 rtl/tmr_intc_if.sv | 30 +++
 rtl/tmr_intc.sv | 70 +++++++
 tb/tb_tmr_intc.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/tmr_intc_if.sv
// tmr_intc_if: bus between the timer interrupt controller and its CPU/timer side
//   irq_src    timer source lines (bit 3*ch + type)
//   mask_we    mask write strobe
//   mask_wdata new mask value, 1 = masked
//   irq_ack    CPU acknowledge of the presented vector
//   irq_req    interrupt request to CPU
//   irq_vec    index of the presented source
//   pending    latched pending flags
//   mask       current mask register
interface tmr_intc_if #(
   parameter int NUM_SRC   = 12,
   parameter int VEC_WIDTH = 4
);
   logic [NUM_SRC-1:0]   irq_src;
   logic                 mask_we;
   logic [NUM_SRC-1:0]   mask_wdata;
   logic                 irq_ack;
   logic                 irq_req;
   logic [VEC_WIDTH-1:0] irq_vec;
   logic [NUM_SRC-1:0]   pending;
   logic [NUM_SRC-1:0]   mask;
   modport master (
      output irq_src, mask_we, mask_wdata, irq_ack,
      input  irq_req, irq_vec, pending, mask
   );
   modport slave (
      input  irq_src, mask_we, mask_wdata, irq_ack,
      output irq_req, irq_vec, pending, mask
   );
endinterface

// File: rtl/tmr_intc.sv
// tmr_intc: edge-latched, maskable, fixed-priority interrupt controller for four 8-bit timer channels
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    tmr_intc_if slave: sources, mask write, CPU request/vector/acknowledge, pending/mask readback
module tmr_intc #(
   parameter int NUM_SRC   = 12,
   parameter int VEC_WIDTH = 4
) (
   input logic       clk,
   input logic       rst_n,
   tmr_intc_if.slave bus
);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] REQ  = 2'd1;
   localparam logic [1:0] GAP  = 2'd2;
   logic [1:0]           state;
   logic [NUM_SRC-1:0]   src_q, rise, eligible, clr, pend, msk;
   logic [VEC_WIDTH-1:0] win, vec;
   logic                 req;
   assign rise     = bus.irq_src & ~src_q;
   assign eligible = pend & ~msk;
   // ack only counts while a vector is actually presented
   assign clr      = (state == REQ && bus.irq_ack) ? NUM_SRC'(1) << vec : '0;
   // scanning downward leaves the lowest set index as winner
   always_comb begin
      win = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--)
         if (eligible[i]) win = VEC_WIDTH'(i);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         src_q <= '0;
         pend  <= '0;
         msk   <= '1;
      end else begin
         src_q <= bus.irq_src;
         // set is applied after clear so a coincident edge keeps the flag
         pend  <= (pend & ~clr) | rise;
         msk   <= bus.mask_we ? bus.mask_wdata : msk;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         req   <= 1'b0;
         vec   <= '0;
      end else begin
         case (state)
            IDLE: if (|eligible) begin
               vec   <= win;
               req   <= 1'b1;
               state <= REQ;
            end
            REQ: if (bus.irq_ack) begin
               req   <= 1'b0;
               state <= GAP;
            end
            GAP: state <= IDLE;
            default: begin
               req   <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end
   assign bus.irq_req = req;
   assign bus.irq_vec = vec;
   assign bus.pending = pend;
   assign bus.mask    = msk;
endmodule

// File: tb/tb_tmr_intc.sv
// tb_tmr_intc: scoreboard bench for tmr_intc with a cycle-level behavioural model
module tb_tmr_intc;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;
   tmr_intc_if #(.NUM_SRC(12), .VEC_WIDTH(4)) b ();
   tmr_intc #(.NUM_SRC(12), .VEC_WIDTH(4)) dut (.clk(clk), .rst_n(rst_n), .bus(b));
   int vecs = 0;
   int miss = 0;
   logic [24:0] st_q[$];
   int          vec_q[$];
   logic [11:0] m_pend, m_mask, m_prev;
   int          m_cur, cyc, free_at;
   logic        prev_req;
   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         miss++;
         $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
      end
   endtask
   function automatic int lowest(input logic [11:0] v);
      for (int i = 0; i < 12; i++) if (v[i]) return i;
      return -1;
   endfunction
   task automatic model_reset();
      m_pend = '0; m_mask = '1; m_prev = '0;
      m_cur = -1; cyc = 0; free_at = 0; prev_req = 1'b0;
   endtask
   // drive one cycle of stimulus and predict the state after the following rising edge
   task automatic step(input logic [11:0] src, input bit we, input logic [11:0] wd, input bit ack);
      logic [11:0] rise, elig;
      @(negedge clk);
      b.irq_src = src; b.mask_we = we; b.mask_wdata = wd; b.irq_ack = ack;
      rise = src & ~m_prev;
      elig = m_pend & ~m_mask;
      if (m_cur >= 0 && ack) begin
         m_pend[m_cur] = 1'b0;
         m_cur = -1;
         free_at = cyc + 2;
      end else if (m_cur < 0 && cyc >= free_at && elig != 0) begin
         m_cur = lowest(elig);
         vec_q.push_back(m_cur);
      end
      m_pend = m_pend | rise;
      if (we) m_mask = wd;
      m_prev = src;
      cyc++;
      st_q.push_back({m_cur >= 0, m_pend, m_mask});
   endtask
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step('0, 0, '0, 0);
   endtask
   task automatic drain();
      for (int i = 0; i < 40; i++) step('0, 0, '0, m_cur >= 0);
   endtask
   initial begin : monitor
      logic [24:0] e;
      int hv;
      hv = 0;
      forever begin
         @(posedge clk);
         #1;
         if (st_q.size() > 0) begin
            e = st_q.pop_front();
            chk("irq_req", 32'(b.irq_req), 32'(e[24]));
            chk("pending", 32'(b.pending), 32'(e[23:12]));
            chk("mask", 32'(b.mask), 32'(e[11:0]));
            if (b.irq_req && !prev_req) begin
               if (vec_q.size() == 0) begin
                  vecs++; miss++;
                  $display("FAIL unexpected_request: got vec %0d expected none", b.irq_vec);
               end else begin
                  hv = vec_q.pop_front();
                  chk("irq_vec", 32'(b.irq_vec), 32'(hv));
               end
            end else if (b.irq_req) chk("irq_vec_hold", 32'(b.irq_vec), 32'(hv));
            prev_req = b.irq_req;
         end
      end
   end
   initial begin
      logic [11:0] s;
      b.irq_src = '0; b.mask_we = 1'b0; b.mask_wdata = '0; b.irq_ack = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_irq_req", 32'(b.irq_req), 0);
      chk("rst_irq_vec", 32'(b.irq_vec), 0);
      chk("rst_pending", 32'(b.pending), 0);
      chk("rst_mask", 32'(b.mask), 32'hfff);
      @(negedge clk);
      rst_n = 1'b1;
      // single-cycle pulse on ch1 OVI with everything unmasked
      step('0, 1, 12'h000, 0);
      step(12'h020, 0, '0, 0);
      idle(2);
      step('0, 0, '0, 1);
      idle(3);
      // masked source latches pending, request appears once unmasked
      step('0, 1, 12'hfff, 0);
      step(12'h001, 0, '0, 0);
      idle(3);
      step('0, 1, 12'hffe, 0);
      idle(2);
      drain();
      // simultaneous sources resolve to the lowest index first
      step('0, 1, 12'h000, 0);
      step(12'h084, 0, '0, 0);
      idle(2);
      step('0, 0, '0, 1);
      idle(3);
      step('0, 0, '0, 1);
      idle(3);
      // higher-priority arrival does not disturb a presented vector
      step(12'h200, 0, '0, 0);
      idle(2);
      step(12'h002, 0, '0, 0);
      idle(2);
      step('0, 0, '0, 1);
      idle(3);
      step('0, 0, '0, 1);
      idle(3);
      // ack coincident with a new edge on the same source
      step(12'h008, 0, '0, 0);
      idle(2);
      step(12'h008, 0, '0, 1);
      idle(3);
      step('0, 0, '0, 1);
      idle(3);
      // level held high produces exactly one request
      for (int i = 0; i < 10; i++) step(12'h010, 0, '0, i == 4);
      drain();
      for (int i = 0; i < 2000; i++) begin
         s = 12'($urandom) & 12'($urandom) & 12'($urandom);
         step(s, $urandom_range(9) == 0, 12'($urandom) & 12'($urandom),
              (m_cur >= 0) ? ($urandom_range(2) == 0) : ($urandom_range(7) == 0));
      end
      drain();
      @(posedge clk);
      #2;
      chk("vec_q_drained", 32'(vec_q.size()), 0);
      // asynchronous reset while a request is outstanding
      step(12'h040, 1, 12'h000, 0);
      for (int i = 0; i < 6 && m_cur < 0; i++) idle(1);
      @(posedge clk);
      #3;
      chk("req_before_rst", 32'(b.irq_req), 1);
      rst_n = 1'b0;
      #1;
      chk("async_rst_irq_req", 32'(b.irq_req), 0);
      chk("async_rst_pending", 32'(b.pending), 0);
      chk("async_rst_mask", 32'(b.mask), 32'hfff);
      st_q.delete();
      vec_q.delete();
      @(posedge clk);
      #2;
      $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
      $finish;
   end
endmodule
